barrel_unshifter: RTL and testbench

Sequential 8-bit right rotator that undoes the left rotation applied by the team's combinational barrel shifter. It sits on the receive side of the lab datapath and restores the original byte from a rotated byte plus the same 3-bit shift amount. It rotates one bit position per clock under a valid/ready handshake. It keeps the shifter's encoding: the all-ones amount means "data cleared" and always yields zero.

---
 rtl/barrel_unshifter_if.sv | 25 ++
 rtl/barrel_unshifter.sv | 94 +++++++++
 tb/tb_barrel_unshifter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_unshifter_if.sv
// Handshake bundle for barrel_unshifter: an input channel (rotated byte plus amount)
// and an output channel (restored byte), each with its own valid/ready pair.
interface barrel_unshifter_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   d_out;
  logic               busy;

  modport master (
    output in_valid, d_in, shift_amount, out_ready,
    input  in_ready, out_valid, d_out, busy
  );

  modport slave (
    input  in_valid, d_in, shift_amount, out_ready,
    output in_ready, out_valid, d_out, busy
  );
endinterface

// File: rtl/barrel_unshifter.sv
// Sequential right rotator that restores a byte rotated left by the companion
// barrel shifter; one bit position per clock, all-ones amount yields zero.
module barrel_unshifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  barrel_unshifter_if.slave bus
);
  localparam logic [SHAMT_W-1:0] CLEAR_CODE = {SHAMT_W{1'b1}};
  localparam logic [SHAMT_W-1:0] ZERO_AMT   = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] ONE_AMT    = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_DATA  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   d_out_r;
  logic               out_valid_r;

  function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  // Control FSM, rotate datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO_AMT;
      data_r      <= ZERO_DATA;
      d_out_r     <= ZERO_DATA;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            data_r <= bus.d_in;
            cnt_r  <= bus.shift_amount;
            if (bus.shift_amount == ZERO_AMT) begin
              d_out_r     <= bus.d_in;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else if (bus.shift_amount == CLEAR_CODE) begin
              d_out_r     <= ZERO_DATA;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r <= ror1(data_r);
          cnt_r  <= cnt_r - ONE_AMT;
          // cnt_r==1 marks the last rotate; its result goes straight to d_out.
          if (cnt_r == ONE_AMT) begin
            d_out_r     <= ror1(data_r);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE) && rst_n;
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.d_out     = d_out_r;

endmodule

// File: tb/tb_barrel_unshifter.sv
// Self-checking bench for barrel_unshifter: directed vector table, backpressure and
// reset sequences, exhaustive round trip, and randomized back-to-back scoreboard.
module tb_barrel_unshifter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  barrel_unshifter_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  barrel_unshifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [7:0] exp_d;
    int         exp_edges;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: right rotate as plain arithmetic on an integer.
  function automatic logic [7:0] ref_unshift(input logic [7:0] d, input logic [2:0] a);
    int x;
    int k;
    x = int'(d);
    k = int'(a);
    if (k == 7) return 8'h00;
    return 8'(((x >> k) | (x << (8 - k))) & 255);
  endfunction

  // Forward barrel shifter: left rotate.
  function automatic logic [7:0] fwd_rot(input logic [7:0] d, input logic [2:0] a);
    int x;
    int k;
    x = int'(d);
    k = int'(a);
    return 8'(((x << k) | (x >> (8 - k))) & 255);
  endfunction

  function automatic int exp_period(input logic [2:0] a);
    return (a == 3'd0 || a == 3'd7) ? 2 : int'(a) + 2;
  endfunction

  // Scoreboard: push expected result on accept, pop and compare on consume.
  logic [7:0] sb_q[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious_result", 1, 0);
        end else begin
          check("sb_data", int'(bus.d_out), int'(sb_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_unshift(bus.d_in, bus.shift_amount));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready=1; reports result, edges from accept to
  // out_valid, and the number of busy cycles.
  task automatic run_txn(input logic [7:0] d, input logic [2:0] a,
                         output logic [7:0] res, output int edges, output int busy_cnt);
    int w;
    bus.out_ready    = 1'b1;
    bus.d_in         = d;
    bus.shift_amount = a;
    bus.in_valid     = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) check("txn_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!bus.out_valid && edges < 40) begin
      busy_cnt += int'(bus.busy);
      tick();
      edges++;
    end
    busy_cnt += int'(bus.busy);
    res = bus.d_out;
    tick();
  endtask

  initial begin
    logic [7:0] res;
    int edges;
    int busy_cnt;
    int w;
    int prev_cyc;
    logic [2:0] prev_a;
    bit valid_seen;

    bus.in_valid     = 1'b0;
    bus.d_in         = 8'h00;
    bus.shift_amount = 3'd0;
    bus.out_ready    = 1'b1;

    vecs[0] = '{8'hB4, 3'd3, 8'h96, 3};
    vecs[1] = '{8'h5A, 3'd0, 8'h5A, 0};
    vecs[2] = '{8'hFF, 3'd7, 8'h00, 0};
    vecs[3] = '{8'h03, 3'd6, 8'h0C, 6};
    vecs[4] = '{8'h01, 3'd1, 8'h80, 1};
    vecs[5] = '{8'h81, 3'd2, 8'h60, 2};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_d_out", int'(bus.d_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready_low", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", int'(bus.in_ready), 1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].d, vecs[i].a, res, edges, busy_cnt);
      check($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].exp_d));
      check($sformatf("vec%0d_latency", i), edges, vecs[i].exp_edges);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].exp_edges + 1);
      check($sformatf("vec%0d_idle_after", i), int'(bus.busy), 0);
    end

    // Backpressure with a competing input held during DONE
    bus.out_ready    = 1'b0;
    bus.d_in         = 8'h01;
    bus.shift_amount = 3'd1;
    bus.in_valid     = 1'b1;
    check("bp_ready_before", int'(bus.in_ready), 1);
    tick();
    bus.d_in         = 8'h77;
    bus.shift_amount = 3'd2;
    tick();
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_data", int'(bus.d_out), 8'h80);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", int'(bus.out_valid), 1);
      check("bp_hold_data", int'(bus.d_out), 8'h80);
      check("bp_hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_release_d_out_kept", int'(bus.d_out), 8'h80);
    tick();
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      tick();
      w++;
    end
    check("bp_second_latency", w, 2);
    check("bp_second_data", int'(bus.d_out), 8'hDD);
    tick();

    // Reset during the second SHIFT cycle
    bus.d_in         = 8'hC3;
    bus.shift_amount = 3'd6;
    bus.in_valid     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("rstmid_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    tick();
    check("rstmid_busy", int'(bus.busy), 0);
    check("rstmid_out_valid", int'(bus.out_valid), 0);
    check("rstmid_d_out", int'(bus.d_out), 0);
    check("rstmid_in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    valid_seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.out_valid) valid_seen = 1'b1;
    end
    check("rstmid_no_pulse", int'(valid_seen), 0);
    run_txn(8'hB4, 3'd3, res, edges, busy_cnt);
    check("rstmid_new_txn", int'(res), 8'h96);

    // Exhaustive round trip through the forward shifter
    for (int v = 0; v < 256; v++) begin
      for (int a = 0; a < 8; a++) begin
        run_txn(fwd_rot(8'(v), 3'(a)), 3'(a), res, edges, busy_cnt);
        check("roundtrip", int'(res), (a == 7) ? 0 : v);
      end
    end

    // Randomized back-to-back throughput
    bus.out_ready = 1'b1;
    prev_cyc = 0;
    prev_a = 3'd0;
    for (int n = 0; n < 150; n++) begin
      bus.d_in         = 8'($urandom);
      bus.shift_amount = 3'($urandom_range(0, 7));
      bus.in_valid     = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 40) begin
        tick();
        w++;
      end
      check("tp_ready_wait", int'(w < 40), 1);
      if (n > 0) check("tp_period", cyc - prev_cyc, exp_period(prev_a));
      prev_cyc = cyc;
      prev_a = bus.shift_amount;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (12) tick();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
